// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, a per-axis timing
// record and the colour bit-replication helper used by vga_timing_core.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    function automatic int timing_total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Repeats the w-bit pattern from its MSB down across ow bits; with ow < w only
    // the MSBs survive. Result is left in the low ow bits.
    function automatic logic [15:0] expand_colour(input logic [15:0] c, input int w, input int ow);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < ow) begin
                r[4'(ow - 1 - i)] = c[4'(w - 1 - (i % w))];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages, W bits wide; DEPTH = 0 is a wire.
module vga_delay_line #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_shift
        logic [W-1:0] stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage[0] <= '0;
            end else if (en) begin
                stage[0] <= d;
            end
        end

        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage[gi] <= '0;
                end else if (en) begin
                    stage[gi] <= stage[gi-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_core.sv
// Configurable VGA raster engine: pixel strobe, raster counters, pipelined sync/blank
// and colour output. Define VGA_TEST_PATTERN_EN to add the test_mode colour-bar input.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 2,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int OUT_W    = 4,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    input  logic [R_W-1:0]   in_r,
    input  logic [G_W-1:0]   in_g,
    input  logic [B_W-1:0]   in_b,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             pix_en,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [OUT_W-1:0] vga_r,
    output logic [OUT_W-1:0] vga_g,
    output logic [OUT_W-1:0] vga_b
);

    localparam vga_timing_t H_T = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
    localparam vga_timing_t V_T = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam int H_TOTAL = timing_total(H_T);
    localparam int V_TOTAL = timing_total(V_T);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_T.active);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_T.active);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_T.active + H_T.fp);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_T.active + H_T.fp + H_T.sync - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_T.active + V_T.fp);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_T.active + V_T.fp + V_T.sync - 1);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_check
        $error("vga_timing_core: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1 || PIPE < 0 || PIPE > 7) begin : g_param_check
        $error("vga_timing_core: CLK_DIV must be >= 1 and PIPE in 0..7");
    end

    logic [DIV_W-1:0] div_cnt;

    // pix_en is registered so it is low in reset and the first strobe lands CLK_DIV clocks after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + CNT_W'(1);
            end else begin
                hc <= hc + CNT_W'(1);
            end
        end
    end

    assign line_start  = pix_en & (hc == '0);
    assign frame_start = line_start & (vc == '0);

    logic act, hs, vs;
    assign act = (hc < H_ACT_C) && (vc < V_ACT_C);
    assign hs  = (hc >= HS_FIRST) && (hc <= HS_LAST);
    assign vs  = (vc >= VS_FIRST) && (vc <= VS_LAST);

`ifdef VGA_TEST_PATTERN_EN
    localparam int DL_W = 3 + CNT_W;
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);
`else
    localparam int DL_W = 3;
`endif

    logic [DL_W-1:0] dl_in, dl_out;
    logic act_d, hs_d, vs_d;

`ifdef VGA_TEST_PATTERN_EN
    logic [CNT_W-1:0] hc_d;
    logic [2:0]       bar;
    assign dl_in = {hc, act, hs, vs};
    assign hc_d  = dl_out[DL_W-1:3];
    assign bar   = 3'(hc_d / BAR_W_C);
`else
    assign dl_in = {act, hs, vs};
`endif
    assign act_d = dl_out[2];
    assign hs_d  = dl_out[1];
    assign vs_d  = dl_out[0];

    vga_delay_line #(
        .W     (DL_W),
        .DEPTH (PIPE)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .d     (dl_in),
        .q     (dl_out)
    );

    logic [OUT_W-1:0] r_next, g_next, b_next;

    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
`ifdef VGA_TEST_PATTERN_EN
        if (act_d && test_mode) begin
            r_next = {OUT_W{bar[2]}};
            g_next = {OUT_W{bar[1]}};
            b_next = {OUT_W{bar[0]}};
        end else if (act_d) begin
`else
        if (act_d) begin
`endif
            r_next = OUT_W'(expand_colour(16'(in_r), R_W, OUT_W));
            g_next = OUT_W'(expand_colour(16'(in_g), G_W, OUT_W));
            b_next = OUT_W'(expand_colour(16'(in_b), B_W, OUT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= ~HS_POL;
            vsync  <= ~VS_POL;
            active <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else if (pix_en) begin
            hsync  <= hs_d ? HS_POL : ~HS_POL;
            vsync  <= vs_d ? VS_POL : ~VS_POL;
            active <= act_d;
            vga_r  <= r_next;
            vga_g  <= g_next;
            vga_b  <= b_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench for vga_timing_core on a reduced 24x10 raster, plus a second
// instance with CLK_DIV=1, HS_POL=1, PIPE=0.
module tb_vga_timing_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] in_r, in_g;
    logic [1:0] in_b;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode;
`endif

    logic [9:0] hc, vc, hc1, vc1;
    logic       pix_en, line_start, frame_start, hsync, vsync, active;
    logic       pix_en1, line_start1, frame_start1, hsync1, vsync1, active1;
    logic [3:0] vga_r, vga_g, vga_b, vga_r1, vga_g1, vga_b1;

    vga_timing_core #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(2),
        .R_W(3), .G_W(3), .B_W(2), .OUT_W(4), .CNT_W(10)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .hc(hc), .vc(vc), .pix_en(pix_en), .line_start(line_start),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .active(active),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    vga_timing_core #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(0),
        .R_W(3), .G_W(3), .B_W(2), .OUT_W(4), .CNT_W(10)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .hc(hc1), .vc(vc1), .pix_en(pix_en1), .line_start(line_start1),
        .frame_start(frame_start1), .hsync(hsync1), .vsync(vsync1), .active(active1),
        .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       ls;
        logic       fs;
    } req_t;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       act;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pin_t;

    req_t       rq[$];
    pin_t       pq[$];
    logic [9:0] hist_h[$];
    logic [9:0] hist_v[$];
    pin_t       blank_pin = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};

    // Input vectors selected by request hc[1:0], with hand-expanded 4-bit results.
    logic [2:0] tab_r [4] = '{3'b101, 3'b010, 3'b111, 3'b001};
    logic [3:0] exp_r [4] = '{4'b1011, 4'b0100, 4'b1111, 4'b0010};
    logic [2:0] tab_g [4] = '{3'b110, 3'b011, 3'b100, 3'b000};
    logic [3:0] exp_g [4] = '{4'b1101, 4'b0110, 4'b1001, 4'b0000};
    logic [1:0] tab_b [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [3:0] exp_b [4] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000};

    // Driver: on each pixel tick, drive colour for the request two ticks back and queue expectations.
    logic [9:0] ref_h, ref_v, dh, dv;
    int         frame_no;
    pin_t       p;
    always @(negedge clk) begin
        if (!rst_n) begin
            ref_h = '0; ref_v = '0; frame_no = 0;
            hist_h.delete(); hist_v.delete(); rq.delete(); pq.delete();
            pq.push_back(blank_pin);
            in_r = '0; in_g = '0; in_b = '0;
`ifdef VGA_TEST_PATTERN_EN
            test_mode = 1'b0;
`endif
        end else if (pix_en) begin
`ifdef VGA_TEST_PATTERN_EN
            test_mode = (frame_no == 1);
`endif
            rq.push_back('{ref_h, ref_v, (ref_h == 0), (ref_h == 0 && ref_v == 0)});
            hist_h.push_back(ref_h);
            hist_v.push_back(ref_v);
            p = blank_pin;
            if (hist_h.size() == 3) begin
                dh = hist_h.pop_front();
                dv = hist_v.pop_front();
                in_r = tab_r[dh[1:0]];
                in_g = tab_g[dh[1:0]];
                in_b = tab_b[dh[1:0]];
                p.hs  = !(dh >= 18 && dh <= 20);
                p.vs  = !(dv >= 7 && dv <= 8);
                p.act = (dh < 16) && (dv < 6);
                if (p.act) begin
`ifdef VGA_TEST_PATTERN_EN
                    if (test_mode) begin
                        p.r = dh[3] ? 4'hF : 4'h0;
                        p.g = dh[2] ? 4'hF : 4'h0;
                        p.b = dh[1] ? 4'hF : 4'h0;
                    end else begin
`else
                    begin
`endif
                        p.r = exp_r[dh[1:0]];
                        p.g = exp_g[dh[1:0]];
                        p.b = exp_b[dh[1:0]];
                    end
                end
            end
            pq.push_back(p);
            if (ref_h == 23) begin
                ref_h = '0;
                if (ref_v == 9) begin
                    ref_v = '0;
                    frame_no++;
                end else begin
                    ref_v++;
                end
            end else begin
                ref_h++;
            end
        end
    end

    // Monitor: pops and compares on pixel ticks; between ticks everything but strobes must hold.
    req_t        er;
    pin_t        ep;
    int          cyc, last_pix;
    bit          have_prev, prev_was_pix;
    logic [34:0] last_vec, cur_vec;
    always @(negedge clk) begin
        #1;
        cur_vec = {hc, vc, hsync, vsync, active, vga_r, vga_g, vga_b};
        if (!rst_n) begin
            have_prev = 0; prev_was_pix = 0; cyc = 0;
            last_vec = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000};
        end else begin
            cyc++;
            if (!prev_was_pix) chk("hold", cur_vec, last_vec);
            if (pix_en) begin
                if (rq.size() == 0 || pq.size() == 0) begin
                    chk("queue_empty", 1, 0);
                end else begin
                    er = rq.pop_front();
                    ep = pq.pop_front();
                    chk("hc", hc, er.h);
                    chk("vc", vc, er.v);
                    chk("line_start", line_start, er.ls);
                    chk("frame_start", frame_start, er.fs);
                    chk("hsync", hsync, ep.hs);
                    chk("vsync", vsync, ep.vs);
                    chk("active", active, ep.act);
                    chk("colour", {vga_r, vga_g, vga_b}, {ep.r, ep.g, ep.b});
                end
                if (have_prev) chk("pix_period", cyc - last_pix, 4);
                have_prev = 1;
                last_pix = cyc;
            end else begin
                chk("strobe_idle", {line_start, frame_start}, 2'b00);
            end
            prev_was_pix = pix_en;
            last_vec = cur_vec;
        end
    end

    // Second instance: strobe every clock, active-high hsync one tick behind the counters.
    logic [9:0] r1h, r1v;
    logic       e_hs1, e_vs1;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            r1h = '0; r1v = '0; e_hs1 = 1'b0; e_vs1 = 1'b1;
        end else begin
            chk("d1_pix_en", pix_en1, 1);
            chk("d1_hc", hc1, r1h);
            chk("d1_vc", vc1, r1v);
            chk("d1_hsync", hsync1, e_hs1);
            chk("d1_vsync", vsync1, e_vs1);
            e_hs1 = (r1h >= 18 && r1h <= 20);
            e_vs1 = !(r1v >= 7 && r1v <= 8);
            if (r1h == 23) begin
                r1h = '0;
                r1v = (r1v == 9) ? 10'd0 : r1v + 10'd1;
            end else begin
                r1h++;
            end
        end
    end

    int cnt;
    bit found;
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_hc", hc, 0);
        chk("rst_vc", vc, 0);
        chk("rst_pix_en", pix_en, 0);
        chk("rst_strobes", {line_start, frame_start}, 0);
        chk("rst_syncs", {hsync, vsync}, 2'b11);
        chk("rst_active", active, 0);
        chk("rst_colour", {vga_r, vga_g, vga_b}, 0);
        chk("rst_d1_hsync", hsync1, 0);
        rst_n = 1'b1;

        cnt = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk); #3;
            if (pix_en) begin found = 1; cnt = i; end
        end
        chk("first_pix_clks", cnt, 4);
        chk("first_frame_start", frame_start, 1);

        repeat (2 * 960) @(negedge clk);

        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk); #2;
            if (pix_en && hc == 10'd10 && vc == 10'd3) found = 1;
        end
        chk("reset_point_found", found, 1);
        chk("pre_reset_active", active, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hc_vc", {hc, vc}, 0);
        chk("mid_rst_strobes", {pix_en, line_start, frame_start}, 0);
        chk("mid_rst_syncs", {hsync, vsync}, 2'b11);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_colour", {vga_r, vga_g, vga_b}, 0);
        chk("mid_rst_d1", {pix_en1, hsync1, vsync1}, 3'b001);

        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        cnt = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk); #3;
            if (frame_start) begin found = 1; cnt = i; end
        end
        chk("restart_frame_start_clks", cnt, 4);

        repeat (700) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
